// File: rtl/uart_dmi_bridge.sv
// UART-to-DMI bridge: a host sends 6-byte request frames over 8N1 serial,
// the bridge issues one DMI request, waits for the response and returns
// the 32-bit data plus 2-bit status as 5 serial bytes.
module uart_dmi_bridge #(
  parameter int CLKS_PER_BIT = 868,
  parameter int GAP_TIMEOUT  = 1000000
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        uart_rx_i,
  output logic        uart_tx_o,
  output logic [1:0]  dmi_req_op_o,
  output logic [31:0] dmi_req_data_o,
  output logic [6:0]  dmi_req_address_o,
  output logic        dmi_req_valid_o,
  input  logic        dmi_req_ready_i,
  input  logic        dmi_rsp_valid_i,
  input  logic [31:0] dmi_rsp_data_i,
  input  logic [1:0]  dmi_rsp_op_i,
  output logic        busy_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int GW = (GAP_TIMEOUT < 1) ? 1 : $clog2(GAP_TIMEOUT + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [GW-1:0] GAP_MAX   = GW'(GAP_TIMEOUT);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [1:0] {ST_RX, ST_ISSUE, ST_WAIT_RSP, ST_TX} state_e;

  // ---------------- input synchronizer ----------------
  logic rx_s1_q, rx_s2_q, rx_s3_q;
  logic rx_fall;

  // Two flops for metastability, a third to detect the start-bit falling edge.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
      rx_s3_q <= 1'b1;
    end else begin
      rx_s1_q <= uart_rx_i;
      rx_s2_q <= rx_s1_q;
      rx_s3_q <= rx_s2_q;
    end
  end

  assign rx_fall = rx_s3_q & ~rx_s2_q;

  // ---------------- RX byte sampler ----------------
  rx_state_e     rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic          rx_done, rx_ferr;

  // Sampler state registers.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
    end
  end

  // Bit-centre sampling; rx_done/rx_ferr pulse in the stop-bit sample cycle.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_done    = 1'b0;
    rx_ferr    = 1'b0;
    unique case (rx_state_q)
      RX_IDLE: begin
        if (rx_fall) begin
          rx_state_d = RX_START;
          rx_cnt_d   = '0;
        end
      end
      RX_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d = '0;
          rx_bit_d = '0;
          // A glitch that is high again at mid-bit is not a start bit.
          rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_state_d = RX_IDLE;
          rx_cnt_d   = '0;
          rx_done    = rx_s2_q;
          rx_ferr    = ~rx_s2_q;
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // ---------------- bridge control and TX ----------------
  state_e        state_q, state_d;
  logic [2:0]    bcnt_q, bcnt_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [6:0]    addr_q, addr_d;
  logic [1:0]    op_q, op_d;
  logic [31:0]   data_q, data_d;
  logic [33:0]   rsp_q, rsp_d;
  logic          tx_q, tx_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [3:0]    tx_bit_q, tx_bit_d;
  logic [2:0]    tx_byte_q, tx_byte_d;
  logic [39:0]   tx_word;
  logic [7:0]    tx_cur;

  assign tx_word = {6'b0, rsp_q};
  assign tx_cur  = tx_word[{tx_byte_q, 3'b000} +: 8];

  // Bridge state registers; all outputs come straight from these flops.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q   <= ST_RX;
      bcnt_q    <= '0;
      gap_q     <= '0;
      addr_q    <= '0;
      op_q      <= '0;
      data_q    <= '0;
      rsp_q     <= '0;
      tx_q      <= 1'b1;
      tx_cnt_q  <= '0;
      tx_bit_q  <= '0;
      tx_byte_q <= '0;
    end else begin
      state_q   <= state_d;
      bcnt_q    <= bcnt_d;
      gap_q     <= gap_d;
      addr_q    <= addr_d;
      op_q      <= op_d;
      data_q    <= data_d;
      rsp_q     <= rsp_d;
      tx_q      <= tx_d;
      tx_cnt_q  <= tx_cnt_d;
      tx_bit_q  <= tx_bit_d;
      tx_byte_q <= tx_byte_d;
    end
  end

  // Frame assembly, DMI handshake, response capture and serial transmit.
  always_comb begin
    state_d   = state_q;
    bcnt_d    = bcnt_q;
    gap_d     = gap_q;
    addr_d    = addr_q;
    op_d      = op_q;
    data_d    = data_q;
    rsp_d     = rsp_q;
    tx_d      = tx_q;
    tx_cnt_d  = tx_cnt_q;
    tx_bit_d  = tx_bit_q;
    tx_byte_d = tx_byte_q;
    unique case (state_q)
      ST_RX: begin
        if (rx_ferr) begin
          // A corrupted byte poisons the whole frame.
          bcnt_d = '0;
          gap_d  = '0;
        end else if (rx_done) begin
          gap_d = '0;
          case (bcnt_q)
            3'd0:    addr_d        = rx_shift_q[6:0];
            3'd1:    op_d          = rx_shift_q[1:0];
            3'd2:    data_d[7:0]   = rx_shift_q;
            3'd3:    data_d[15:8]  = rx_shift_q;
            3'd4:    data_d[23:16] = rx_shift_q;
            default: data_d[31:24] = rx_shift_q;
          endcase
          if (bcnt_q == 3'd5) begin
            bcnt_d  = '0;
            state_d = ST_ISSUE;
          end else begin
            bcnt_d = bcnt_q + 3'd1;
          end
        end else if (bcnt_q != 3'd0 && rx_state_q == RX_IDLE) begin
          // Stale partial frame: drop it once the line has idled too long.
          if (gap_q == GAP_MAX) begin
            bcnt_d = '0;
            gap_d  = '0;
          end else begin
            gap_d = gap_q + GW'(1);
          end
        end
      end
      ST_ISSUE: begin
        if (dmi_req_ready_i) state_d = ST_WAIT_RSP;
      end
      ST_WAIT_RSP: begin
        if (dmi_rsp_valid_i) begin
          rsp_d     = {dmi_rsp_op_i, dmi_rsp_data_i};
          state_d   = ST_TX;
          tx_d      = 1'b0;
          tx_cnt_d  = '0;
          tx_bit_d  = '0;
          tx_byte_d = '0;
        end
      end
      ST_TX: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 4'd9) begin
            if (tx_byte_q == 3'd4) begin
              state_d = ST_RX;
              tx_d    = 1'b1;
            end else begin
              // Next start bit follows the stop bit with no idle gap.
              tx_byte_d = tx_byte_q + 3'd1;
              tx_bit_d  = '0;
              tx_d      = 1'b0;
            end
          end else begin
            tx_bit_d = tx_bit_q + 4'd1;
            tx_d     = (tx_bit_q == 4'd8) ? 1'b1 : tx_cur[tx_bit_q[2:0]];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      default: state_d = ST_RX;
    endcase
  end

  assign uart_tx_o         = tx_q;
  assign dmi_req_valid_o   = (state_q == ST_ISSUE);
  assign dmi_req_op_o      = op_q;
  assign dmi_req_data_o    = data_q;
  assign dmi_req_address_o = addr_q;
  assign busy_o            = (state_q != ST_RX);

endmodule

// File: tb/tb_uart_dmi_bridge.sv
// Directed bench for uart_dmi_bridge with scoreboard queues for DMI requests
// and returned serial bytes; monitors check independently of the stimulus.
module tb_uart_dmi_bridge;

  localparam int CPB = 4;
  localparam int GAP = 200;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        uart_rx_i = 1'b1;
  logic        uart_tx_o;
  logic [1:0]  dmi_req_op_o;
  logic [31:0] dmi_req_data_o;
  logic [6:0]  dmi_req_address_o;
  logic        dmi_req_valid_o;
  logic        dmi_req_ready_i = 1'b1;
  logic        dmi_rsp_valid_i = 1'b0;
  logic [31:0] dmi_rsp_data_i = '0;
  logic [1:0]  dmi_rsp_op_i = '0;
  logic        busy_o;

  uart_dmi_bridge #(.CLKS_PER_BIT(CPB), .GAP_TIMEOUT(GAP)) dut (
    .clk_i(clk),
    .reset_i(reset_i),
    .uart_rx_i(uart_rx_i),
    .uart_tx_o(uart_tx_o),
    .dmi_req_op_o(dmi_req_op_o),
    .dmi_req_data_o(dmi_req_data_o),
    .dmi_req_address_o(dmi_req_address_o),
    .dmi_req_valid_o(dmi_req_valid_o),
    .dmi_req_ready_i(dmi_req_ready_i),
    .dmi_rsp_valid_i(dmi_rsp_valid_i),
    .dmi_rsp_data_i(dmi_rsp_data_i),
    .dmi_rsp_op_i(dmi_rsp_op_i),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int rst_epoch = 0;
  logic [40:0] exp_req_q[$];  // {address, op, data}
  logic [7:0]  exp_tx_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge reset_i) rst_epoch++;

  // DMI request monitor: every handshake must match the next queued request.
  logic [40:0] req_e;
  always @(negedge clk) begin
    if (reset_i && dmi_req_valid_o === 1'b1 && dmi_req_ready_i) begin
      if (exp_req_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_req: got addr 0x%0h op %0d data 0x%0h, expected none",
                 dmi_req_address_o, dmi_req_op_o, dmi_req_data_o);
      end else begin
        req_e = exp_req_q.pop_front();
        chk("req_addr", 64'(dmi_req_address_o), 64'(req_e[40:34]));
        chk("req_op",   64'(dmi_req_op_o),      64'(req_e[33:32]));
        chk("req_data", 64'(dmi_req_data_o),    64'(req_e[31:0]));
      end
    end
  end

  // Serial TX monitor: decodes bytes at bit centres; bytes cut by reset are dropped.
  logic [7:0] mon_b;
  logic       mon_stop;
  int         mon_ep;
  initial begin
    forever begin
      @(negedge uart_tx_o);
      mon_ep = rst_epoch;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clk);
        mon_b[i] = uart_tx_o;
      end
      repeat (CPB) @(negedge clk);
      mon_stop = uart_tx_o;
      if (mon_ep == rst_epoch) begin
        if (exp_tx_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_tx_byte: got 0x%0h, expected none", mon_b);
        end else begin
          chk("tx_byte", 64'(mon_b), 64'(exp_tx_q.pop_front()));
          chk("tx_stop", 64'(mon_stop), 64'd1);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stopb);
    uart_rx_i = 1'b0;
    ticks(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rx_i = b[i];
      ticks(CPB);
    end
    uart_rx_i = stopb;
    ticks(CPB);
    uart_rx_i = 1'b1;
  endtask

  task automatic send_frame(input logic [6:0] addr, input logic [1:0] op, input logic [31:0] data);
    send_byte({1'b0, addr}, 1'b1);
    send_byte({6'b0, op}, 1'b1);
    send_byte(data[7:0], 1'b1);
    send_byte(data[15:8], 1'b1);
    send_byte(data[23:16], 1'b1);
    send_byte(data[31:24], 1'b1);
  endtask

  // One full transaction; ntx < 5 leaves TX running for the reset scenario.
  task automatic do_req(input logic [6:0] addr, input logic [1:0] op, input logic [31:0] data,
                        input int hold, input logic [31:0] rdata, input logic [1:0] rop,
                        input int ntx);
    logic [39:0] w;
    int cyc;
    exp_req_q.push_back({addr, op, data});
    if (hold > 0) dmi_req_ready_i = 1'b0;
    send_frame(addr, op, data);
    cyc = 0;
    while (dmi_req_valid_o !== 1'b1 && cyc < 200) begin
      tick();
      cyc++;
    end
    if (dmi_req_valid_o !== 1'b1) begin
      vectors++;
      miscompares++;
      $display("FAIL req_valid_timeout: got valid=0 after %0d cycles, expected valid=1", cyc);
      dmi_req_ready_i = 1'b1;
      return;
    end
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("valid_held", 64'(dmi_req_valid_o), 64'd1);
    end
    if (hold > 0) chk("addr_held", 64'(dmi_req_address_o), 64'(addr));
    // Response pulse coincident with the transfer must not be captured.
    dmi_req_ready_i = 1'b1;
    dmi_rsp_valid_i = 1'b1;
    dmi_rsp_data_i  = ~rdata;
    dmi_rsp_op_i    = ~rop;
    tick();
    chk("valid_drop", 64'(dmi_req_valid_o), 64'd0);
    w = {6'b0, rop, rdata};
    for (int k = 0; k < ntx; k++) exp_tx_q.push_back(w[8*k +: 8]);
    dmi_rsp_data_i = rdata;
    dmi_rsp_op_i   = rop;
    tick();
    dmi_rsp_valid_i = 1'b0;
    chk("busy_during_tx", 64'(busy_o), 64'd1);
    if (ntx == 5) begin
      cyc = 0;
      while (busy_o && cyc < 400) begin
        tick();
        cyc++;
      end
      chk("busy_after_tx", 64'(busy_o), 64'd0);
    end
  endtask

  initial begin
    #2 reset_i = 1'b0;
    ticks(3);
    chk("rst_tx",    64'(uart_tx_o), 64'd1);
    chk("rst_valid", 64'(dmi_req_valid_o), 64'd0);
    chk("rst_op",    64'(dmi_req_op_o), 64'd0);
    chk("rst_data",  64'(dmi_req_data_o), 64'd0);
    chk("rst_addr",  64'(dmi_req_address_o), 64'd0);
    chk("rst_busy",  64'(busy_o), 64'd0);
    reset_i = 1'b1;
    ticks(5);

    // Read 0x10, zero response -> 00 00 00 00 00
    do_req(7'h10, 2'd1, 32'h0000_0000, 0, 32'h0000_0000, 2'd0, 5);
    // Write with ready held low for 7 cycles
    do_req(7'h04, 2'd2, 32'hDEAD_BEEF, 7, 32'h1234_ABCD, 2'd1, 5);
    // Read 0x11 -> 82 03 03 00 00
    do_req(7'h11, 2'd1, 32'h0000_0000, 0, 32'h0003_0382, 2'd0, 5);

    // Stale partial frame is flushed by the gap timeout
    send_byte(8'h10, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    ticks(250);
    do_req(7'h10, 2'd1, 32'h0000_0000, 0, 32'hCAFE_F00D, 2'd3, 5);

    // Framing error on B2 drops the partial frame
    send_byte(8'h10, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'hEF, 1'b0);
    ticks(20);
    do_req(7'h22, 2'd3, 32'h0102_0304, 0, 32'h5A5A_5A5A, 2'd2, 5);

    // Reset in the middle of TX byte 2: only bytes 11 22 go out
    do_req(7'h33, 2'd1, 32'h0000_0000, 0, 32'h4433_2211, 2'd3, 2);
    ticks(85);
    reset_i = 1'b0;
    #1;
    chk("rst_mid_tx_tx",    64'(uart_tx_o), 64'd1);
    chk("rst_mid_tx_busy",  64'(busy_o), 64'd0);
    chk("rst_mid_tx_valid", 64'(dmi_req_valid_o), 64'd0);
    chk("tx_bytes_before_rst", 64'(exp_tx_q.size()), 64'd0);
    ticks(3);
    reset_i = 1'b1;
    ticks(300);
    chk("idle_after_rst_tx",   64'(uart_tx_o), 64'd1);
    chk("idle_after_rst_busy", 64'(busy_o), 64'd0);
    do_req(7'h7F, 2'd3, 32'h1234_5678, 0, 32'h8765_4321, 2'd0, 5);

    ticks(20);
    chk("req_queue_empty", 64'(exp_req_q.size()), 64'd0);
    chk("tx_queue_empty",  64'(exp_tx_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
